// File: rtl/f1_light_ctrl.sv
// f1_light_ctrl: start-light sequencer with tick divider and LFSR random hold.
// Optional macro TRIG_RESTART_EN: trigger during FILL/HOLD restarts the sequence.
module f1_light_ctrl #(
    parameter int WIDTH = 8,
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             trigger,
    input  logic [DIV_W-1:0] N,
    output logic [WIDTH-1:0] lights,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, FILL, HOLD} state_t;

    state_t           state;
    state_t           state_n;
    logic [DIV_W-1:0] cnt;
    logic [6:0]       lfsr;
    logic [6:0]       delay_cnt;
    logic [6:0]       delay_n;
    logic [WIDTH-1:0] lights_n;
    logic             done_n;
    logic             reload;
    logic             tick;

    assign tick = en && (cnt == '0);

    // Tick divider: counts down while enabled, reloads N after each tick
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (reload) begin
            cnt <= N;
        end else if (en) begin
            cnt <= (cnt == '0) ? N : cnt - DIV_W'(1);
        end
    end

    // Free-running x^7+x^6+1 LFSR supplying the random hold length
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= 7'h01;
        end else begin
            lfsr <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};
        end
    end

`ifdef TRIG_RESTART_EN
    logic last_tick;
    assign last_tick = (state == HOLD) && tick && (delay_cnt <= 7'd1);
`endif

    // Sequence FSM: next state, next light pattern and done pulse
    always_comb begin
        state_n  = state;
        lights_n = lights;
        delay_n  = delay_cnt;
        done_n   = 1'b0;
        reload   = 1'b0;
        unique case (state)
            IDLE: begin
                lights_n = '0;
                if (trigger) begin
                    state_n = FILL;
                end
            end
            FILL: begin
                if (tick) begin
                    lights_n = {lights[WIDTH-2:0], 1'b1};
                    if (&lights[WIDTH-2:0]) begin
                        delay_n = lfsr;
                        state_n = HOLD;
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    if (delay_cnt > 7'd1) begin
                        delay_n = delay_cnt - 7'd1;
                    end else begin
                        lights_n = '0;
                        done_n   = 1'b1;
                        state_n  = IDLE;
                    end
                end
            end
            default: begin
                lights_n = '0;
                state_n  = IDLE;
            end
        endcase
`ifdef TRIG_RESTART_EN
        // The finishing tick wins so the done pulse is never swallowed
        if (trigger && (state != IDLE) && !last_tick) begin
            lights_n = '0;
            reload   = 1'b1;
            state_n  = FILL;
        end
`endif
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            lights    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            delay_cnt <= '0;
        end else begin
            state     <= state_n;
            lights    <= lights_n;
            busy      <= (state_n != IDLE);
            done      <= done_n;
            delay_cnt <= delay_n;
        end
    end

endmodule
